// File: rtl/sync_event_sched.sv
`default_nettype none
// ============================================================================
// Module   : sync_event_sched
// Brief    : Per-slot delayed digital events merged round-robin onto one
//            valid/ready sync port. Define SYNC_EVENT_SCHED_INERTIAL_EN for
//            inertial (replace pending) requests; default is transport (stall).
// Revision : 1.0 - initial release
// ============================================================================
module sync_event_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_val,
    input  logic [NREQ*DW-1:0]      req_dly,
    output logic [NREQ-1:0]         req_ack,
    output logic [NREQ-1:0]         busy,
    output logic                    out_valid,
    output logic [$clog2(NREQ)-1:0] out_id,
    output logic                    out_val,
    input  logic                    out_ready,
    output logic [15:0]             evt_cnt,
    output logic [15:0]             cancel_cnt
);

    localparam int c_IW   = $clog2(NREQ);
    localparam int c_SUMW = c_IW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DUE  = 2'd2
    } slot_state_t;

    logic [NREQ-1:0] w_due;
    logic [NREQ-1:0] w_val_vec;
    logic [NREQ-1:0] w_grant_vec;
    logic [NREQ-1:0] w_due_rot;
    logic [NREQ-1:0] w_val_rot;
    logic            w_load;
    logic            w_grant_any;
    logic [c_IW-1:0] w_grant_id;
    logic            w_grant_val;
    logic [c_SUMW-1:0] w_sum;

    logic [c_IW-1:0] r_rr;
    logic            r_out_valid;
    logic [c_IW-1:0] r_out_id;
    logic            r_out_val;
    logic [15:0]     r_evt_cnt;

`ifdef SYNC_EVENT_SCHED_INERTIAL_EN
    logic [NREQ-1:0] w_repl_vec;
    logic [15:0]     w_cancel_inc;
    logic [15:0]     r_cancel_cnt;
`endif

    // The stage may take a new event when empty or when the current one leaves.
    assign w_load = !r_out_valid || out_ready;

    // Rotate so bit 0 is the slot after the last grant; first set bit wins.
    assign w_due_rot = NREQ'({w_due, w_due} >> r_rr);
    assign w_val_rot = NREQ'({w_val_vec, w_val_vec} >> r_rr);

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_grant_val = 1'b0;
        w_sum       = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_grant_any && w_due_rot[k]) begin
                w_grant_any = 1'b1;
                w_grant_val = w_val_rot[k];
                w_sum       = {1'b0, r_rr} + c_SUMW'(k);
                if (w_sum >= c_SUMW'(NREQ)) begin
                    w_sum = w_sum - c_SUMW'(NREQ);
                end
                w_grant_id  = w_sum[c_IW-1:0];
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        slot_state_t   r_state;
        slot_state_t   w_state_nxt;
        logic [DW-1:0] r_cnt;
        logic [DW-1:0] w_cnt_nxt;
        logic          r_val;
        logic          w_val_nxt;
        logic          r_ack;
        logic          w_cap;
        logic          w_repl;
        logic [DW-1:0] w_dly;

        assign w_dly = req_dly[i*DW +: DW];
        assign w_grant_vec[i] = w_load && w_grant_any && (w_grant_id == c_IW'(i));

`ifdef SYNC_EVENT_SCHED_INERTIAL_EN
        // A request on a pending slot replaces it unless the slot leaves this edge.
        assign w_repl = req[i] && ((r_state == S_WAIT) ||
                                   ((r_state == S_DUE) && !w_grant_vec[i]));
        assign w_repl_vec[i] = w_repl;
`else
        assign w_repl = 1'b0;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_val   <= 1'b0;
                r_ack   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_val   <= w_val_nxt;
                r_ack   <= w_cap;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_val_nxt   = r_val;
            w_cap       = 1'b0;
            case (r_state)
                S_IDLE: begin
                    w_cap = req[i];
                end
                S_WAIT: begin
                    if (w_repl) begin
                        w_cap = 1'b1;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = S_DUE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                S_DUE: begin
                    // A grant with req high recaptures directly, skipping IDLE.
                    if (w_grant_vec[i]) begin
                        w_state_nxt = S_IDLE;
                        w_cap       = req[i];
                    end else if (w_repl) begin
                        w_cap = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
            if (w_cap) begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = w_dly;
                w_val_nxt   = req_val[i];
            end
        end

        assign w_due[i]     = (r_state == S_DUE);
        assign w_val_vec[i] = r_val;
        assign busy[i]      = (r_state != S_IDLE);
        assign req_ack[i]   = r_ack;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_val   <= 1'b0;
            r_rr        <= '0;
            r_evt_cnt   <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_evt_cnt <= r_evt_cnt + 16'd1;
            end
            if (w_load) begin
                r_out_valid <= w_grant_any;
                if (w_grant_any) begin
                    r_out_id  <= w_grant_id;
                    r_out_val <= w_grant_val;
                    r_rr      <= (w_grant_id == c_IW'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;
                end
            end
        end
    end

`ifdef SYNC_EVENT_SCHED_INERTIAL_EN
    always_comb begin
        w_cancel_inc = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cancel_inc = w_cancel_inc + 16'(w_repl_vec[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cancel_cnt <= '0;
        end else begin
            r_cancel_cnt <= r_cancel_cnt + w_cancel_inc;
        end
    end

    assign cancel_cnt = r_cancel_cnt;
`else
    assign cancel_cnt = 16'h0000;
`endif

    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign out_val   = r_out_val;
    assign evt_cnt   = r_evt_cnt;

endmodule
`default_nettype wire

// File: doc/sync_event_sched.md
SYNC_EVENT_SCHED -- requirements
Module: sync_event_sched

Interface
REQ-001 Parameter NREQ, default 4: number of digital gate requesters (slots), 2..8.
REQ-002 Parameter DW, default 8: delay field width in clock ticks.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: asynchronous active-low reset.
REQ-005 Port req  input  NREQ: per-slot event request, level-sampled each edge.
REQ-006 Port req_val  input  NREQ: logic value to deliver for each slot.
REQ-007 Port req_dly  input  NREQ*DW: per-slot delay in ticks; slot i uses bits [i*DW +: DW].
REQ-008 Port req_ack  output  NREQ: registered one-cycle pulse confirming capture.
REQ-009 Port busy  output  NREQ: slot holds a pending event (WAIT or DUE).
REQ-010 Port out_valid  output  1: event presented to the analog sync port.
REQ-011 Port out_id  output  clog2(NREQ): slot index of the presented event.
REQ-012 Port out_val  output  1: value of the presented event.
REQ-013 Port out_ready  input  1: analog side accepts the event when high with out_valid.
REQ-014 Port evt_cnt  output  16: delivered-event count.
REQ-015 Port cancel_cnt  output  16: replaced-event count.

Function
REQ-016 Each slot SHALL be an FSM with states IDLE, WAIT and DUE, holding a DW-bit countdown and a 1-bit value.
REQ-017 IDLE with req[i] high at edge E0 SHALL load the value and delay, enter WAIT, and pulse req_ack[i] during the cycle after E0.
REQ-018 In WAIT, each edge SHALL enter DUE if the count is 0 and otherwise decrement it; delay d reaches DUE at edge E(d+1).
REQ-019 The output stage SHALL be one register, loadable when empty or when out_valid and out_ready are both high in the same cycle.
REQ-020 When loadable, the stage SHALL grant one DUE slot round-robin, searching from the last granted slot plus 1; the granted slot SHALL return to IDLE on that edge.
REQ-021 With no contention and out_ready high, out_valid SHALL rise at edge E(d+2).
REQ-022 out_valid, out_id and out_val SHALL hold stable while out_valid is high and out_ready is low.
REQ-023 If a slot is granted while its req is high, the slot SHALL capture the new event at the same edge and SHALL NOT pass through a visible IDLE cycle.
REQ-024 A DUE slot not granted SHALL remain DUE; no event SHALL be lost or duplicated.
REQ-025 evt_cnt SHALL increment on each out_valid and out_ready handshake and wrap from 0xFFFF to 0.
REQ-026 busy[i] SHALL be high exactly when slot i is in WAIT or DUE.

Reset
REQ-027 When rst_n is low, all slots SHALL go to IDLE asynchronously with counts and values at 0.
REQ-028 When rst_n is low, out_valid, out_id, out_val, req_ack, busy, evt_cnt and cancel_cnt SHALL be 0 and the round-robin pointer SHALL select slot 0 first.
REQ-029 Reset mid-operation SHALL discard all pending and presented events, with no handshake counted.

Configuration
REQ-030 Macro SYNC_EVENT_SCHED_INERTIAL_EN defined: req in WAIT or DUE (not being granted) SHALL replace the pending value and delay, re-enter WAIT, pulse req_ack, and increment cancel_cnt (wrapping).
REQ-031 Macro undefined: req in WAIT or DUE SHALL be stalled with no req_ack until the slot is granted (transport semantics), and cancel_cnt SHALL be tied to 0.

Verification
REQ-032 Slot 0 req with val=1 and dly=30, out_ready=1 -> req_ack[0] pulses 1 cycle later, out_valid=1 with out_id=0 and out_val=1 at E32, evt_cnt=1.
REQ-033 Slots 0-3 req at the same edge with dly=0, out_ready=1 -> out_valid on 4 consecutive cycles with out_id order 0,1,2,3; second burst -> order continues 0,1,2,3.
REQ-034 out_ready=0 for 10 cycles with an event presented -> outputs stable and other slots stay DUE; out_ready=1 -> all events delivered, none lost.
REQ-035 Slot 1 dly=20 val=0, then at cycle 5 a req with val=1 and dly=3 -> with the macro, a single event val=1 at cycle 10 and cancel_cnt=1; without the macro, no ack until val=0 is delivered, then val=1 delivered.
REQ-036 rst_n low during WAIT and while out_valid is high -> all outputs 0 immediately; after release, a new req with dly=0 is delivered with out_id=0 priority.
